fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Decoupling FIFO between the fetch stage and decode. Buffers fetch_data_t entries (pc, raw instruction data, branch prediction bp) pushed by fetch.
- Presents the oldest entry to decode with a valid/ready handshake, absorbing the one-cycle bubble that decode inserts for jal/jalr uop splitting.
- Flushed completely on squash. Optional empty-queue fall-through keeps fetch-to-decode latency at 0 cycles.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
BYPASS, 1, 1 = when empty, input passes combinationally to output; 0 = minimum 1-cycle latency

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_i  input  fetch_data_t  entry from fetch
in_i_valid  input  1  entry present
in_i_ready  output  1  queue accepts an entry this cycle
out_o  output  fetch_data_t  oldest entry, to decode in_i
out_o_valid  output  1  out_o valid
out_o_ready  input  1  decode consumes out_o (decode in_i_ready)
squash_io  squash_if.slave  -  flush request; only .valid is used
count_o  output  $clog2(DEPTH)+1  occupancy after the current edge, for perf counters

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage: DEPTH x fetch_data_t circular buffer. Head/tail pointers are $clog2(DEPTH) bits and wrap naturally. count register is $clog2(DEPTH)+1 bits.
- Reset (rst=1 at edge): head=tail=0, count=0. Storage contents are don't-care.
- Outputs while in reset: out_o_valid=0, in_i_ready=0, count_o=0.
- push = in_i_valid && in_i_ready && !squash_io.valid && !bypass_taken.
- pop = out_o_valid && out_o_ready && (count!=0).
- in_i_ready = !rst && !squash_io.valid && (count < DEPTH).
  - Depends only on registered state and squash. No combinational path from out_o_ready, so a full queue does not accept in the same cycle as a pop.
- out_o / out_o_valid:
  - count!=0: out_o = mem[head]; out_o_valid = !squash_io.valid.
  - count==0 and BYPASS=1: out_o = in_i; out_o_valid = in_i_valid && !squash_io.valid && !rst.
  - count==0 and BYPASS=0: out_o_valid = 0.
  - out_o is '0 whenever out_o_valid=0.
- bypass_taken = BYPASS && count==0 && in_i_valid && out_o_ready && out_o_valid. The entry is consumed directly and not written.
- Ordering: strict FIFO; entries are never reordered or duplicated. While out_o_valid=1 && out_o_ready=0, out_o holds stable across cycles.
- Update per edge (priority order):
  - rst: clear.
  - squash_io.valid: head=tail=0, count=0; push, pop and bypass of this cycle are discarded.
  - otherwise: push writes mem[tail] and increments tail; pop increments head; count += push - pop. Simultaneous push and pop leaves count unchanged.
- Boundaries:
  - Full (count==DEPTH): in_i_ready=0 even if popping.
  - Empty with BYPASS=0: a push becomes visible the next cycle.
  - Wrap: pointer DEPTH-1 goes to 0.
  - Squash that coincides with a full queue and with in_i_valid drops every entry, including in_i.
  - Reset asserted mid-operation behaves exactly like a squash, plus outputs are forced as listed for reset.
- count_o = count register. The value is post-edge, registered, and has no combinational dependence on inputs.
- Assertions:
  - count <= DEPTH.
  - No push when full.
  - out_o stable while valid && !ready && !squash.

Decomposition:
- fetch_data_t, bp_t and squash_if already live in the shared package C / existing interfaces. No new typedefs are needed beyond a local pointer width derived from DEPTH.
- A sub-module is not natural: the storage is a plain register array inferred in-module. If reuse is wanted later, the pointer/count logic can be extracted as fifo_ctrl.

Test Plan:
- Reset, then push pc 0x80000000/0x80000004/0x80000008 with out_o_ready=0 -> count_o 1,2,3; after ready=1, out_o pops in the same pc order, one per cycle.
- DEPTH=4, fill 4 entries -> in_i_ready=0; a pop in that cycle still leaves in_i_ready=0; the next cycle in_i_ready=1 and count_o=3.
- Push 10 entries pc 0x100+4k with ready toggling 1,0,1,0 -> all 10 exit in order, exercising pointer wrap twice; no loss or duplication (scoreboard).
- 3 entries queued plus in_i_valid, then squash_io.valid=1 for one cycle -> out_o_valid=0 and in_i_ready=0 that cycle; count_o=0 next cycle; the next push pc 0x200 is the first output.
- BYPASS=1, empty, in_i_valid and out_o_ready=1 with pc 0x300 -> out_o.pc=0x300 the same cycle and count_o stays 0. With BYPASS=0 the same entry appears one cycle later.
- rst asserted with 2 entries queued -> out_o_valid=0 and in_i_ready=0 during reset; after release count_o=0 and the old entries never appear.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_queue_pkg                                             |
// | Brief  : Shared fetch-stage types used by the fetch queue and decode |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_queue_pkg;

  // Branch prediction attached to a fetched instruction
  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } bp_t;

  // One fetched instruction as handed from fetch to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    bp_t         bp;
  } fetch_data_t;

  // Occupancy counter width for a queue of the given depth (holds 0..DEPTH)
  function automatic int unsigned fq_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : squash_if / fetch_queue_if                                  |
// | Brief  : Pipeline flush request and fetch-to-decode queue handshakes |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

// Pipeline flush request; consumers only look at valid
interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// Fetch-side push port, decode-side pop port and occupancy of the queue.
// master = the surrounding pipeline (fetch + decode), slave = the queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  fetch_data_t                in_i;
  logic                       in_i_valid;
  logic                       in_i_ready;
  fetch_data_t                out_o;
  logic                       out_o_valid;
  logic                       out_o_ready;
  logic [$clog2(DEPTH):0]     count_o;

  modport master (
    output in_i, in_i_valid, out_o_ready,
    input  in_i_ready, out_o, out_o_valid, count_o
  );

  modport slave (
    input  in_i, in_i_valid, out_o_ready,
    output in_i_ready, out_o, out_o_valid, count_o
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : fetch_queue                                                 |
// | Brief  : Fetch-to-decode decoupling FIFO with squash flush and       |
// |          optional empty-queue fall-through                           |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,   // power of two, >= 2
  parameter bit BYPASS = 1'b1 // 1: empty queue passes input straight through
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_queue_if.slave fq,
  squash_if.slave      squash_io
);

  localparam int                  c_PTR_W     = $clog2(DEPTH);
  localparam int                  c_CNT_W     = fq_cnt_width(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);

  fetch_data_t           r_mem [DEPTH];
  logic [c_PTR_W-1:0]    r_head;
  logic [c_PTR_W-1:0]    r_tail;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_in_ready;
  logic                  w_out_valid;
  fetch_data_t           w_out;
  logic                  w_bypass_taken;
  logic                  w_push;
  logic                  w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_DEPTH_CNT);

  // Acceptance depends on registered state and squash only, so a full
  // queue never accepts in the same cycle it pops.
  assign w_in_ready = !rst && !squash_io.valid && !w_full;

  // Output selection: stored head entry, fall-through input, or idle zeros
  always_comb begin
    w_out_valid = 1'b0;
    w_out       = '0;
    if (!w_empty) begin
      w_out_valid = !squash_io.valid && !rst;
      if (w_out_valid) begin
        w_out = r_mem[r_head];
      end
    end else if (BYPASS) begin
      w_out_valid = fq.in_i_valid && !squash_io.valid && !rst;
      if (w_out_valid) begin
        w_out = fq.in_i;
      end
    end
  end

  // A fall-through entry that decode takes immediately is never stored
  assign w_bypass_taken = BYPASS && w_empty && fq.in_i_valid && fq.out_o_ready && w_out_valid;
  assign w_push         = fq.in_i_valid && w_in_ready && !squash_io.valid && !w_bypass_taken;
  assign w_pop          = w_out_valid && fq.out_o_ready && !w_empty;

  // Pointer and occupancy update; squash discards this cycle's traffic
  always_ff @(posedge clk) begin
    if (rst || squash_io.valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= fq.in_i;
    end
  end

  assign fq.in_i_ready  = w_in_ready;
  assign fq.out_o_valid = w_out_valid;
  assign fq.out_o       = w_out;
  assign fq.count_o     = r_count;

  a_count_bound : assert property (@(posedge clk) r_count <= c_DEPTH_CNT);

  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(w_push && w_full));

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (w_out_valid && !fq.out_o_ready && !squash_io.valid) |=>
      (rst || squash_io.valid || (w_out_valid && $stable(w_out))));

endmodule
`default_nettype wire
